// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data/address widths and the sequencer state encoding,
// used by the sequencer, its memory interface and the CPU top level.
package cpu_pkg;

  localparam int N = 32;
  localparam int M = 16;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    HALT    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Shared instruction/data memory port: one request at a time, completed by mem_ready.
interface cpu_sequencer_if;
  import cpu_pkg::*;

  logic         mem_req;
  logic         mem_we;
  logic [M-1:0] mem_addr;
  logic         mem_ready;
  logic [N-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );

endinterface

// File: rtl/cpu_sequencer.sv
// Multicycle CPU sequencer: owns pc/ir/mdr/instret and walks each instruction
// through FETCH, DECODE, EXECUTE, optional MEM and WB over a shared memory port.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [M-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  is_halted,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  reg_write,
  input  logic                  is_jump,
  input  logic                  is_branch,
  input  logic [N-1:0]          imm,
  input  logic [N-1:0]          alu_result,
  cpu_sequencer_if.master       mem,
  output logic [N-1:0]          ir,
  output logic [N-1:0]          mdr,
  output logic [M-1:0]          pc,
  output logic [M-1:0]          pc_link,
  output logic                  reg_we,
  output logic [2:0]            state,
  output logic                  halted,
  output logic [31:0]           instret
);

  seq_state_t   state_q;
  logic         fetch_pending;
  logic [M-1:0] pc_next;
  logic         unused_bits;

  assign state       = state_q;
  assign pc_link     = pc + M'(1);
  assign unused_bits = ^{imm[N-1:M], alu_result[N-1:M]};

  // rst_n gates the fetch request so it drops the instant reset is applied,
  // even while run is still high.
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.mem_addr = pc;
    reg_we       = 1'b0;
    halted       = 1'b0;
    case (state_q)
      FETCH:   mem.mem_req = rst_n && (run || fetch_pending);
      MEM: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = mem_write;
        mem.mem_addr = alu_result[M-1:0];
      end
      WB:      reg_we = reg_write && !mem_write;
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pc_next = pc + M'(1);
    if (is_jump)
      pc_next = alu_result[M-1:0];
    else if (is_branch && alu_result[0])
      pc_next = pc + M'(1) + imm[M-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc            <= RESET_PC;
      ir            <= '0;
      mdr           <= '0;
      instret       <= '0;
      fetch_pending <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (mem.mem_req) begin
            if (mem.mem_ready) begin
              ir            <= mem.mem_rdata;
              fetch_pending <= 1'b0;
              state_q       <= DECODE;
            end else begin
              fetch_pending <= 1'b1;
            end
          end
        end
        DECODE:  state_q <= is_halted ? HALT : EXECUTE;
        EXECUTE: state_q <= (mem_read || mem_write) ? MEM : WB;
        MEM: begin
          if (mem.mem_ready) begin
            if (mem_read)
              mdr <= mem.mem_rdata;
            state_q <= WB;
          end
        end
        WB: begin
          instret <= instret + 32'd1;
          pc      <= pc_next;
          state_q <= FETCH;
        end
        HALT:    ;
        default: state_q <= HALT;
      endcase
    end
  end

endmodule
